// File: rtl/ps2_host_rx_if.sv
// Bundle of the PS/2 line pair, inhibit output and FIFO read side of ps2_host_rx.
// slave = receiver side, master = the logic driving the lines and reading bytes.
interface ps2_host_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       rd;
  logic [7:0] dout;
  logic       empty;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  modport slave (
    input  ps2_clk, ps2_data, rd,
    output ps2_clk_oe, dout, empty, frame_err, overflow, busy
  );

  modport master (
    output ps2_clk, ps2_data, rd,
    input  ps2_clk_oe, dout, empty, frame_err, overflow, busy
  );
endinterface

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: sync + glitch filter, framing FSM with timeout, FWFT byte FIFO.
// Optional device inhibit while the FIFO is full is enabled by defining PS2_RX_INHIBIT_EN.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data=0 on a strobe)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit and parity, pushing the byte
module ps2_host_rx #(
  parameter int FIFO_AW        = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 21000
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  ps2_host_rx_if.slave bus
);

  localparam int FCW   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [FCW-1:0]   FCNT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [FCW-1:0]   FCNT_ONE  = FCW'(1);
  localparam logic [TW-1:0]    TCNT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    TCNT_ONE  = TW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic strobe;
  logic inhibit;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       par_q, par_d;
  logic [TW-1:0] tcnt_q;
  logic       timeout;
  logic       push;
  logic       err_d;
  logic       ferr_q, ovf_q;

  logic [7:0]     mem [DEPTH];
  logic [FIFO_AW:0] wp_q, rp_q;
  logic           full, empty_w, pop, wr, ovf_d;

  // Both line synchronisers reset to the idle-high bus level.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // fcnt tracks how many consecutive synced samples have disagreed with the filtered level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    strobe = 1'b0;
    if (inhibit) begin
      filt_d = 1'b1;
    end else if (clk_s2 != filt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_d = clk_s2;
        strobe = filt_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      par_q   <= par_d;
      ferr_q  <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    push    = 1'b0;
    err_d   = 1'b0;
    timeout = (state_q != S_IDLE) && (tcnt_q == '0);
    if (strobe) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shreg_d = {dat_s2, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (dat_s2 && (^{shreg_q, par_q})) push = 1'b1;
          else err_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  // Mid-frame watchdog: reloads on every strobe and while idle, expires at zero.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tcnt_q <= TCNT_LOAD;
    end else if (strobe || (state_q == S_IDLE)) begin
      tcnt_q <= TCNT_LOAD;
    end else if (tcnt_q != '0) begin
      tcnt_q <= tcnt_q - TCNT_ONE;
    end
  end

  assign empty_w = (wp_q == rp_q);
  assign full    = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                   (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign pop     = bus.rd && !empty_w;
  assign wr      = push && (!full || pop);
  assign ovf_d   = push && full && !pop;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + PTR_ONE;
      if (pop) rp_q <= rp_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr) mem[wp_q[FIFO_AW-1:0]] <= shreg_q;
  end

  assign bus.dout      = empty_w ? 8'h00 : mem[rp_q[FIFO_AW-1:0]];
  assign bus.empty     = empty_w;
  assign bus.frame_err = ferr_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = (state_q != S_IDLE);

`ifdef PS2_RX_INHIBIT_EN
  logic oe_q;

  // Only asserted between frames so a byte in flight is never truncated.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) oe_q <= 1'b0;
    else          oe_q <= full && (state_q == S_IDLE);
  end

  assign inhibit        = oe_q;
  assign bus.ps2_clk_oe = oe_q;
`else
  assign inhibit        = 1'b0;
  assign bus.ps2_clk_oe = 1'b0;
`endif

endmodule
